// File: rtl/exhaustive_vector_checker_if.sv
// Bus between the lab top level (master) and the exhaustive truth-table checker (slave).
// Carries sweep control, the golden table, DUT stimulus/response and the result flags.
interface exhaustive_vector_checker_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
);
  logic                        start;
  logic [(2**N_IN)*N_OUT-1:0]  golden;
  logic [N_OUT-1:0]            resp_in;
  logic [N_IN-1:0]             vec_out;
  logic                        busy;
  logic                        done;
  logic                        pass;
  logic [N_IN:0]               err_count;
  logic [N_IN-1:0]             first_fail_idx;
  logic                        first_fail_vld;

  modport master (
    output start, golden, resp_in,
    input  vec_out, busy, done, pass, err_count, first_fail_idx, first_fail_vld
  );

  modport slave (
    input  start, golden, resp_in,
    output vec_out, busy, done, pass, err_count, first_fail_idx, first_fail_vld
  );
endinterface

// File: rtl/exhaustive_vector_checker.sv
// Exhaustive truth-table sweep: drives vectors 0..2^N_IN-1, holds each for DWELL cycles,
// compares the DUT response on the last dwell cycle against the golden table.
module exhaustive_vector_checker #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int DWELL = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  exhaustive_vector_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // A one-cycle dwell still needs a 1-bit counter so the compare decode stays uniform.
  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0]   VEC_LAST = '1;
  localparam logic [N_IN-1:0]   VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]     ERR_ONE  = (N_IN + 1)'(1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_IN:0]       err_q, err_d;
  logic [N_IN-1:0]     ffi_q, ffi_d;
  logic                ffv_q, ffv_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [N_OUT-1:0]    exp_resp;
  logic                mismatch;

  assign exp_resp = bus.golden[N_OUT*int'(vec_q) +: N_OUT];
  assign mismatch = (bus.resp_in != exp_resp);

  // NOTE: every *_d gets its hold value first, so no path through the case leaves a
  // signal unassigned and no latch is inferred; blocking '=' is correct inside always_comb.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      S_RUN: begin
        // start is deliberately not looked at here: a running sweep cannot be restarted.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (!ffv_q) begin
              ffi_d = vec_q;
              ffv_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            // Final sample: vec_out holds, verdict uses the count including this vector.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + VEC_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vec_out        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.first_fail_vld = ffv_q;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Scoreboard bench for exhaustive_vector_checker (N_IN=3, N_OUT=2, DWELL=4) driving a
// lab circuit C=A&B, E=B^D; expected sweep results come from a truth-table model.
module tb_exhaustive_vector_checker;

  localparam int N_IN  = 3;
  localparam int N_OUT = 2;
  localparam int DWELL = 4;
  localparam int NVEC  = 2**N_IN;
  localparam int GW    = NVEC*N_OUT;

  typedef struct {
    logic [N_IN:0]   err;
    logic [N_IN-1:0] ffi;
    logic            ffv;
    logic            pass;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   run_k    = 0;
  logic prev_done = 1'b0;
  exp_t sb_q[$];

  exhaustive_vector_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  exhaustive_vector_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Lab circuit under test: inputs A (MSB), B, D (LSB); outputs {C, E}.
  function automatic logic [N_OUT-1:0] lab(input logic [N_IN-1:0] v);
    return {v[2] & v[1], v[1] ^ v[0]};
  endfunction

  assign bus.resp_in = lab(bus.vec_out);

  function automatic logic [GW-1:0] correct_golden();
    logic [GW-1:0] g;
    g = '0;
    for (int v = 0; v < NVEC; v++) g[v*N_OUT +: N_OUT] = lab(N_IN'(v));
    return g;
  endfunction

  function automatic exp_t model_sweep(input logic [GW-1:0] g);
    exp_t e;
    e.err = '0; e.ffi = '0; e.ffv = 1'b0;
    for (int v = 0; v < NVEC; v++) begin
      if (g[v*N_OUT +: N_OUT] != lab(N_IN'(v))) begin
        if (!e.ffv) begin
          e.ffi = N_IN'(v);
          e.ffv = 1'b1;
        end
        e.err = e.err + 1'b1;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic start_sweep(input logic [GW-1:0] g);
    bus.golden = g;
    sb_q.push_back(model_sweep(g));
    pulse_start();
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("done_timeout", 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_vec"},  32'(bus.vec_out),        0);
    check({tag, "_busy"}, 32'(bus.busy),           0);
    check({tag, "_done"}, 32'(bus.done),           0);
    check({tag, "_pass"}, 32'(bus.pass),           0);
    check({tag, "_err"},  32'(bus.err_count),      0);
    check({tag, "_ffi"},  32'(bus.first_fail_idx), 0);
    check({tag, "_ffv"},  32'(bus.first_fail_vld), 0);
  endtask

  // Monitor: tracks vector stepping while busy, scores results on each rising done.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      run_k     = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) begin
        check("vec_step", 32'(bus.vec_out), 32'(run_k / DWELL));
        run_k++;
      end
      if (bus.done && !prev_done) begin
        check("run_len", 32'(run_k), 32'(NVEC*DWELL));
        check("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("err_count", 32'(bus.err_count), 32'(e.err));
          check("pass", 32'(bus.pass), 32'(e.pass));
          check("ff_vld", 32'(bus.first_fail_vld), 32'(e.ffv));
          if (e.ffv) check("ff_idx", 32'(bus.first_fail_idx), 32'(e.ffi));
          check("vec_hold", 32'(bus.vec_out), NVEC - 1);
          check("busy_off", 32'(bus.busy), 0);
        end
        run_k = 0;
      end
      if (!bus.busy && !bus.done) run_k = 0;
      prev_done = bus.done;
    end
  end

  initial begin
    logic [GW-1:0] good;
    logic [GW-1:0] flip5;
    bit            found;
    good  = correct_golden();
    flip5 = good ^ (GW'(1) << (5*N_OUT));

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.golden = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_clear("reset");

    start_sweep(good);
    wait_done(200);

    start_sweep(flip5);
    wait_done(200);

    start_sweep(~good);
    wait_done(200);

    // Start from DONE (previous sweep had 8 errors): results must clear at once.
    start_sweep(flip5);
    check("restart_done", 32'(bus.done), 0);
    check("restart_err",  32'(bus.err_count), 0);
    check("restart_vec",  32'(bus.vec_out), 0);
    check("restart_busy", 32'(bus.busy), 1);
    check("restart_ffv",  32'(bus.first_fail_vld), 0);
    repeat (9) @(negedge clk);
    pulse_start();
    wait_done(200);

    // Asynchronous reset in the middle of a sweep.
    start_sweep(good);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.vec_out == 3) found = 1'b1;
    end
    check("reach_vec3", 32'(found), 1);
    #2 reset = 1'b1;
    sb_q.delete();
    #1 check_all_clear("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    start_sweep(good);
    wait_done(200);

    for (int r = 0; r < 8; r++) begin
      logic [GW-1:0] mask;
      mask = (r % 3 == 0) ? '0 : GW'($urandom_range(0, (1 << GW) - 1));
      start_sweep(good ^ mask);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, NVEC*DWELL - 3)) @(negedge clk);
        pulse_start();
      end
      wait_done(200);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
